nabp_shifter_array: RTL and testbench



---
 rtl/nabp_shifter_pkg.sv | 29 ++
 rtl/nabp_shifter_lane.sv | 50 +++++
 rtl/nabp_shifter_array.sv | 126 ++++++++++++
 tb/tb_nabp_shifter_array.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/nabp_shifter_pkg.sv
// Shared types and constants for the NABP shifter array.
// Build option: define NABP_SHIFTER_HALF_OFFSET_EN to start every shift-phase
// accumulator at 0.5 (round-to-nearest mapping) instead of 0 (floor mapping).
package nabp_shifter_pkg;

  typedef enum logic [1:0] {
    StReady    = 2'd0,
    StFill     = 2'd1,
    StFillDone = 2'd2,
    StShift    = 2'd3
  } state_e;

`ifdef NABP_SHIFTER_HALF_OFFSET_EN
  localparam bit AccuInitHalf = 1'b1;
`else
  localparam bit AccuInitHalf = 1'b0;
`endif

  // Counter wide enough to hold the value n itself.
  function automatic int unsigned cnt_width(int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Accumulator start value for a fraction of the given width.
  function automatic int unsigned accu_init(int unsigned frac);
    return AccuInitHalf ? (32'd1 << (frac - 1)) : 32'd0;
  endfunction

endpackage

// File: rtl/nabp_shifter_lane.sv
// One filter-mapper lane: latched base, fractional accumulator and strobe flop.
// The strobe is the carry out of the accumulator, i.e. an integer crossing.
module nabp_shifter_lane
  import nabp_shifter_pkg::*;
#(
  parameter int unsigned ACCU_FRAC = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 step,
  input  logic                 clear,
  input  logic [ACCU_FRAC-1:0] base_in,
  output logic                 strobe
);

  localparam logic [ACCU_FRAC-1:0] AccuInit = ACCU_FRAC'(accu_init(ACCU_FRAC));

  logic [ACCU_FRAC-1:0] base_q;
  logic [ACCU_FRAC-1:0] accu_q;
  logic                 strobe_q;
  logic [ACCU_FRAC:0]   sum_load;
  logic [ACCU_FRAC:0]   sum_step;

  // Load folds in the first step so the strobe for shift cycle 1 is ready in cycle 1.
  always_comb begin
    sum_load = {1'b0, AccuInit} + {1'b0, base_in};
    sum_step = {1'b0, accu_q} + {1'b0, base_q};
  end

  // Base latch, accumulate with wrap modulo 1, strobe on carry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      accu_q   <= '0;
      strobe_q <= 1'b0;
    end else if (load) begin
      base_q               <= base_in;
      {strobe_q, accu_q}   <= sum_load;
    end else if (step) begin
      {strobe_q, accu_q}   <= sum_step;
    end else if (clear) begin
      accu_q   <= '0;
      strobe_q <= 1'b0;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/nabp_shifter_array.sv
// NABP shifter array: fill/shift sequencer driving NUM_CH filter-mapper lanes.
// Fill holds every lane enabled for FILL_LEN cycles; shift strobes each lane on
// its own accumulator carries for IMAGE_SIZE cycles.
// Build option NABP_SHIFTER_HALF_OFFSET_EN selects the accumulator start value.
module nabp_shifter_array
  import nabp_shifter_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned IMAGE_SIZE = 128,
  parameter int unsigned FILL_LEN   = 16,
  parameter int unsigned ACCU_FRAC  = 10
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CH*ACCU_FRAC-1:0]   sl_accu_base,
  input  logic                          sc_fill_kick,
  input  logic                          sc_shift_kick,
  output logic                          sc_fill_done,
  output logic                          sc_shift_done,
  output logic [NUM_CH-1:0]             fm_shift_enable,
  output logic                          busy
);

  localparam int unsigned FillW  = cnt_width(FILL_LEN);
  localparam int unsigned ShiftW = cnt_width(IMAGE_SIZE);
  localparam logic [FillW-1:0]  FillLast  = FillW'(FILL_LEN);
  localparam logic [ShiftW-1:0] ShiftLast = ShiftW'(IMAGE_SIZE);

  state_e              state_q;
  logic [FillW-1:0]    fill_cnt_q;
  logic [ShiftW-1:0]   shift_cnt_q;
  logic                fill_en_q;
  logic                fill_done_q;
  logic                shift_done_q;
  logic                busy_q;
  logic                lane_load;
  logic                lane_step;
  logic                lane_clear;
  logic [NUM_CH-1:0]   lane_strobe;

  // Counters hold the number of the cycle currently shown on the outputs (1-based).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StReady;
      fill_cnt_q   <= '0;
      shift_cnt_q  <= '0;
      fill_en_q    <= 1'b0;
      fill_done_q  <= 1'b0;
      shift_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        StReady: begin
          if (sc_fill_kick) begin
            state_q     <= StFill;
            fill_cnt_q  <= FillW'(1);
            fill_en_q   <= 1'b1;
            fill_done_q <= (FillLast == FillW'(1));
            busy_q      <= 1'b1;
          end
        end
        StFill: begin
          if (fill_cnt_q == FillLast) begin
            state_q     <= StFillDone;
            fill_cnt_q  <= '0;
            fill_en_q   <= 1'b0;
            fill_done_q <= 1'b0;
          end else begin
            fill_cnt_q  <= fill_cnt_q + FillW'(1);
            fill_done_q <= ((fill_cnt_q + FillW'(1)) == FillLast);
          end
        end
        StFillDone: begin
          if (sc_shift_kick) begin
            state_q      <= StShift;
            shift_cnt_q  <= ShiftW'(1);
            shift_done_q <= (ShiftLast == ShiftW'(1));
          end
        end
        StShift: begin
          if (shift_cnt_q == ShiftLast) begin
            state_q      <= StReady;
            shift_cnt_q  <= '0;
            shift_done_q <= 1'b0;
            busy_q       <= 1'b0;
          end else begin
            shift_cnt_q  <= shift_cnt_q + ShiftW'(1);
            shift_done_q <= ((shift_cnt_q + ShiftW'(1)) == ShiftLast);
          end
        end
        default: begin
          state_q <= StReady;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Lane controls: load on the shift kick, step through the pass, clear on exit.
  always_comb begin
    lane_load  = (state_q == StFillDone) && sc_shift_kick;
    lane_step  = (state_q == StShift) && (shift_cnt_q != ShiftLast);
    lane_clear = (state_q == StShift) && (shift_cnt_q == ShiftLast);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    nabp_shifter_lane #(
      .ACCU_FRAC(ACCU_FRAC)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (lane_load),
      .step    (lane_step),
      .clear   (lane_clear),
      .base_in (sl_accu_base[c*ACCU_FRAC +: ACCU_FRAC]),
      .strobe  (lane_strobe[c])
    );
  end

  // Lane strobes are zero outside shift, so OR-ing in the fill enable is safe.
  assign fm_shift_enable = lane_strobe | {NUM_CH{fill_en_q}};
  assign sc_fill_done    = fill_done_q;
  assign sc_shift_done   = shift_done_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_nabp_shifter_array.sv
// Directed bench for nabp_shifter_array (NUM_CH=2, IMAGE_SIZE=8, FILL_LEN=3, ACCU_FRAC=4).
module tb_nabp_shifter_array;

  logic       clk;
  logic       reset_n;
  logic [7:0] sl_accu_base;
  logic       sc_fill_kick;
  logic       sc_shift_kick;
  logic       sc_fill_done;
  logic       sc_shift_done;
  logic [1:0] fm_shift_enable;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  nabp_shifter_array #(
    .NUM_CH    (2),
    .IMAGE_SIZE(8),
    .FILL_LEN  (3),
    .ACCU_FRAC (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sl_accu_base   (sl_accu_base),
    .sc_fill_kick   (sc_fill_kick),
    .sc_shift_kick  (sc_shift_kick),
    .sc_fill_done   (sc_fill_done),
    .sc_shift_done  (sc_shift_done),
    .fm_shift_enable(fm_shift_enable),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " en"}, 32'(fm_shift_enable), 32'h0);
    check({tag, " busy"}, 32'(busy), 32'h0);
    check({tag, " fdone"}, 32'(sc_fill_done), 32'h0);
    check({tag, " sdone"}, 32'(sc_shift_done), 32'h0);
  endtask

  // Fill pass of 3 cycles; optionally hold the shift kick with the fill kick.
  task automatic do_fill(input string tag, input logic with_shift);
    sc_fill_kick  = 1'b1;
    sc_shift_kick = with_shift;
    tick();
    sc_fill_kick  = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("%s fill en c%0d", tag, k), 32'(fm_shift_enable), 32'h3);
      check($sformatf("%s fill done c%0d", tag, k), 32'(sc_fill_done), 32'(k == 3));
      check($sformatf("%s fill busy c%0d", tag, k), 32'(busy), 32'h1);
      if (k == 1) sc_shift_kick = 1'b0;
      if (k < 3) tick();
    end
    tick();
    check({tag, " filldone en"}, 32'(fm_shift_enable), 32'h0);
    check({tag, " filldone fdone"}, 32'(sc_fill_done), 32'h0);
    check({tag, " filldone busy"}, 32'(busy), 32'h1);
    // Waiting state must hold without a shift kick.
    tick();
    check({tag, " wait en"}, 32'(fm_shift_enable), 32'h0);
    check({tag, " wait busy"}, 32'(busy), 32'h1);
  endtask

  // Shift pass; exp bit k-1 is the lane strobe in shift cycle k.
  task automatic do_shift(input string tag, input logic [3:0] b0, input logic [3:0] b1,
                          input logic [7:0] exp0, input logic [7:0] exp1,
                          input logic poke_fill);
    sl_accu_base  = {b1, b0};
    sc_shift_kick = 1'b1;
    tick();
    sc_shift_kick = 1'b0;
    sl_accu_base  = 8'hff;  // must be ignored after the kick
    for (int k = 1; k <= 8; k++) begin
      sc_fill_kick = poke_fill && (k >= 2) && (k <= 5);
      check($sformatf("%s en c%0d", tag, k), 32'(fm_shift_enable),
            32'({exp1[k-1], exp0[k-1]}));
      check($sformatf("%s sdone c%0d", tag, k), 32'(sc_shift_done), 32'(k == 8));
      check($sformatf("%s busy c%0d", tag, k), 32'(busy), 32'h1);
      if (k < 8) tick();
    end
    sc_fill_kick = 1'b0;
    tick();
    check_idle({tag, " end"});
    tick();
    check_idle({tag, " end+1"});
  endtask

  initial begin
    logic [7:0] e_b8;
    logic [7:0] e_b15;
    logic [7:0] e_b5;
`ifdef NABP_SHIFTER_HALF_OFFSET_EN
    e_b8  = 8'b01010101;
    e_b15 = 8'b11111111;
    e_b5  = 8'b10010010;
`else
    e_b8  = 8'b10101010;
    e_b15 = 8'b11111110;
    e_b5  = 8'b01001000;
`endif
    reset_n       = 1'b0;
    sl_accu_base  = 8'h00;
    sc_fill_kick  = 1'b0;
    sc_shift_kick = 1'b0;
    #1;
    check_idle("reset async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_idle("reset");

    // Shift kick in READY is ignored.
    sc_shift_kick = 1'b1;
    tick();
    sc_shift_kick = 1'b0;
    check_idle("shift kick in ready");
    tick();
    check_idle("shift kick in ready +1");

    // Both kicks in READY: only fill starts; fill kicks during SHIFT ignored.
    do_fill("both kicks", 1'b1);
    do_shift("b8/0", 4'd8, 4'd0, e_b8, 8'h00, 1'b1);

    do_fill("pass2", 1'b0);
    do_shift("b15/5", 4'd15, 4'd5, e_b15, e_b5, 1'b0);

    // Reset in shift cycle 4 aborts at once with no done pulse.
    do_fill("pre-reset", 1'b0);
    sl_accu_base  = {4'd0, 4'd8};
    sc_shift_kick = 1'b1;
    tick();
    sc_shift_kick = 1'b0;
    repeat (3) tick();
    check("abort c4 en", 32'(fm_shift_enable), 32'({1'b0, e_b8[3]}));
    check("abort c4 busy", 32'(busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("abort async");
    for (int k = 0; k < 6; k++) begin
      tick();
      check_idle($sformatf("abort hold %0d", k));
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_idle($sformatf("abort after %0d", k));
    end

    do_fill("post-reset", 1'b0);
    do_shift("post-reset b8/0", 4'd8, 4'd0, e_b8, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
